// File: rtl/cv32e40p_id_issue_ctrl.sv
// ID issue control: accepts the IF/ID entry, holds multi-cycle instructions, and issues them to EX.
// Latency: single-cycle instructions issue in the accept cycle; N extra cycles issue N cycles later.
// Backpressure: ex_ready_i low stalls issue and freezes the multi-cycle count; halt and flush gate IF.
module cv32e40p_id_issue_ctrl #(
   parameter int unsigned MC_W  = 4,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid_id_i,
   input  logic [31:0]      instr_rdata_id_i,
   input  logic [31:0]      pc_id_i,
   input  logic             is_compressed_id_i,
   input  logic             illegal_c_insn_id_i,
   input  logic             is_fetch_failed_i,
   input  logic [MC_W-1:0]  mc_cycles_i,
   input  logic             ex_ready_i,
   input  logic             halt_req_i,
   input  logic             flush_i,
   output logic             id_ready_o,
   output logic             clear_instr_valid_o,
   output logic             halt_if_o,
   output logic [31:0]      dec_instr_o,
   output logic [31:0]      dec_pc_o,
   output logic             dec_is_compressed_o,
   output logic             dec_illegal_o,
   output logic             fetch_err_o,
   output logic             id_valid_o,
   output logic [CNT_W-1:0] instr_cnt_o
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      MULTI = 2'd1,
      HALT  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [MC_W-1:0]   mc_cnt_q, mc_cnt_d;
   logic [CNT_W-1:0]  instr_cnt_q;

   logic st_run, st_multi, st_halt;
   logic issue_run, issue_multi;

   assign st_run   = (state_q == RUN);
   assign st_multi = (state_q == MULTI);
   assign st_halt  = (state_q == HALT);

   assign issue_run   = st_run & instr_valid_id_i & ~flush_i & (mc_cycles_i == '0) & ex_ready_i;
   assign issue_multi = st_multi & ~flush_i & ex_ready_i & (mc_cnt_q == MC_W'(1));

   assign id_valid_o          = issue_run | issue_multi;
   assign id_ready_o          = ~flush_i & ((st_run & (~instr_valid_id_i | issue_run)) |
                                            (st_multi & id_valid_o));
   assign clear_instr_valid_o = id_valid_o | flush_i;
   assign halt_if_o           = halt_req_i | st_halt;

   assign dec_instr_o         = instr_rdata_id_i;
   assign dec_pc_o            = pc_id_i;
   assign dec_is_compressed_o = is_compressed_id_i;
   assign dec_illegal_o       = illegal_c_insn_id_i & instr_valid_id_i;
   assign fetch_err_o         = st_run & ~instr_valid_id_i & is_fetch_failed_i & ~flush_i;

   assign instr_cnt_o = instr_cnt_q;

   // Next state and multi-cycle count; flush overrides everything and abandons a partial MULTI.
   always_comb begin
      state_d  = state_q;
      mc_cnt_d = mc_cnt_q;
      if (flush_i) begin
         mc_cnt_d = '0;
         state_d  = halt_req_i ? HALT : RUN;
      end else begin
         unique case (state_q)
            RUN: begin
               // A halt leaves a stalled or multi-cycle instruction in IF/ID for reissue later.
               if (halt_req_i) begin
                  state_d = HALT;
               end else if (instr_valid_id_i && (mc_cycles_i != '0)) begin
                  mc_cnt_d = mc_cycles_i;
                  state_d  = MULTI;
               end
            end
            MULTI: begin
               if (ex_ready_i) begin
                  if (mc_cnt_q == MC_W'(1)) begin
                     mc_cnt_d = '0;
                     state_d  = halt_req_i ? HALT : RUN;
                  end else begin
                     mc_cnt_d = mc_cnt_q - MC_W'(1);
                  end
               end
            end
            HALT: begin
               if (!halt_req_i) state_d = RUN;
            end
            default: begin
               state_d  = RUN;
               mc_cnt_d = '0;
            end
         endcase
      end
   end

   // State, multi-cycle count and issued-instruction counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         mc_cnt_q    <= '0;
         instr_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         mc_cnt_q <= mc_cnt_d;
         if (id_valid_o) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_cv32e40p_id_issue_ctrl.sv
// Directed bench for cv32e40p_id_issue_ctrl with a 4-bit instruction counter.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Expected values are hand-derived per step; a running expected count tracks issues.
module tb_cv32e40p_id_issue_ctrl;

   localparam int MC_W  = 4;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic             instr_valid_id_i;
   logic [31:0]      instr_rdata_id_i;
   logic [31:0]      pc_id_i;
   logic             is_compressed_id_i;
   logic             illegal_c_insn_id_i;
   logic             is_fetch_failed_i;
   logic [MC_W-1:0]  mc_cycles_i;
   logic             ex_ready_i;
   logic             halt_req_i;
   logic             flush_i;
   logic             id_ready_o;
   logic             clear_instr_valid_o;
   logic             halt_if_o;
   logic [31:0]      dec_instr_o;
   logic [31:0]      dec_pc_o;
   logic             dec_is_compressed_o;
   logic             dec_illegal_o;
   logic             fetch_err_o;
   logic             id_valid_o;
   logic [CNT_W-1:0] instr_cnt_o;

   int n_chk  = 0;
   int n_pass = 0;
   logic [CNT_W-1:0] exp_cnt;

   cv32e40p_id_issue_ctrl #(.MC_W(MC_W), .CNT_W(CNT_W)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .instr_valid_id_i    (instr_valid_id_i),
      .instr_rdata_id_i    (instr_rdata_id_i),
      .pc_id_i             (pc_id_i),
      .is_compressed_id_i  (is_compressed_id_i),
      .illegal_c_insn_id_i (illegal_c_insn_id_i),
      .is_fetch_failed_i   (is_fetch_failed_i),
      .mc_cycles_i         (mc_cycles_i),
      .ex_ready_i          (ex_ready_i),
      .halt_req_i          (halt_req_i),
      .flush_i             (flush_i),
      .id_ready_o          (id_ready_o),
      .clear_instr_valid_o (clear_instr_valid_o),
      .halt_if_o           (halt_if_o),
      .dec_instr_o         (dec_instr_o),
      .dec_pc_o            (dec_pc_o),
      .dec_is_compressed_o (dec_is_compressed_o),
      .dec_illegal_o       (dec_illegal_o),
      .fetch_err_o         (fetch_err_o),
      .id_valid_o          (id_valid_o),
      .instr_cnt_o         (instr_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance one clock; bump the expected count if this cycle was expected to issue.
   task automatic tick(input bit issued);
      @(posedge clk);
      #1;
      if (issued) exp_cnt = exp_cnt + 4'd1;
   endtask

   initial begin
      rst_n               = 1'b0;
      instr_valid_id_i    = 1'b0;
      instr_rdata_id_i    = 32'h0000_0013;
      pc_id_i             = 32'h0;
      is_compressed_id_i  = 1'b0;
      illegal_c_insn_id_i = 1'b0;
      is_fetch_failed_i   = 1'b0;
      mc_cycles_i         = '0;
      ex_ready_i          = 1'b1;
      halt_req_i          = 1'b0;
      flush_i             = 1'b0;
      exp_cnt             = '0;

      // Reset state: RUN with empty IF/ID.
      #2;
      chk("rst_id_ready", 32'(id_ready_o), 32'd1);
      chk("rst_id_valid", 32'(id_valid_o), 32'd0);
      chk("rst_halt_if", 32'(halt_if_o), 32'd0);
      chk("rst_cnt", 32'(instr_cnt_o), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 1. Four back-to-back single-cycle instructions.
      for (int i = 0; i < 4; i++) begin
         instr_valid_id_i   = 1'b1;
         pc_id_i            = 32'h1000 + 32'(4 * i);
         instr_rdata_id_i   = 32'h0010_0093 + 32'(i);
         is_compressed_id_i = (i == 2);
         #1;
         chk("b2b_valid", 32'(id_valid_o), 32'd1);
         chk("b2b_clear", 32'(clear_instr_valid_o), 32'd1);
         chk("b2b_ready", 32'(id_ready_o), 32'd1);
         chk("b2b_pc", dec_pc_o, 32'h1000 + 32'(4 * i));
         chk("b2b_instr", dec_instr_o, 32'h0010_0093 + 32'(i));
         chk("b2b_cmp", 32'(dec_is_compressed_o), (i == 2) ? 32'd1 : 32'd0);
         tick(1'b1);
      end
      is_compressed_id_i = 1'b0;
      instr_valid_id_i   = 1'b0;
      #1;
      chk("b2b_cnt4", 32'(instr_cnt_o), 32'd4);

      // 2. mc_cycles_i=3: three stalled cycles, issue on the fourth.
      instr_valid_id_i = 1'b1;
      pc_id_i          = 32'h100;
      mc_cycles_i      = 4'd3;
      #1;
      chk("mc3_c0_ready", 32'(id_ready_o), 32'd0);
      chk("mc3_c0_valid", 32'(id_valid_o), 32'd0);
      tick(1'b0);
      mc_cycles_i = 4'd7;   // ignored while in MULTI
      for (int i = 1; i < 3; i++) begin
         #1;
         chk("mc3_stall_ready", 32'(id_ready_o), 32'd0);
         chk("mc3_stall_valid", 32'(id_valid_o), 32'd0);
         tick(1'b0);
      end
      #1;
      chk("mc3_issue_valid", 32'(id_valid_o), 32'd1);
      chk("mc3_issue_ready", 32'(id_ready_o), 32'd1);
      chk("mc3_issue_clear", 32'(clear_instr_valid_o), 32'd1);
      tick(1'b1);
      instr_valid_id_i = 1'b0;
      mc_cycles_i      = '0;
      #1;
      chk("mc3_back_run", 32'(id_ready_o), 32'd1);
      chk("mc3_cnt", 32'(instr_cnt_o), 32'(exp_cnt));

      // 3. mc_cycles_i=2 with two ex_ready_i-low cycles mid-MULTI.
      instr_valid_id_i = 1'b1;
      mc_cycles_i      = 4'd2;
      tick(1'b0);
      ex_ready_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("mc2_hold_valid", 32'(id_valid_o), 32'd0);
         chk("mc2_hold_cnt", 32'(instr_cnt_o), 32'(exp_cnt));
         tick(1'b0);
      end
      ex_ready_i = 1'b1;
      #1;
      chk("mc2_dec_valid", 32'(id_valid_o), 32'd0);
      tick(1'b0);
      chk("mc2_issue_valid", 32'(id_valid_o), 32'd1);
      tick(1'b1);
      instr_valid_id_i = 1'b0;
      mc_cycles_i      = '0;
      #1;
      chk("mc2_cnt", 32'(instr_cnt_o), 32'(exp_cnt));

      // 4. Flush while MULTI count is 2.
      instr_valid_id_i = 1'b1;
      mc_cycles_i      = 4'd3;
      tick(1'b0);
      tick(1'b0);
      flush_i = 1'b1;
      #1;
      chk("flush_valid", 32'(id_valid_o), 32'd0);
      chk("flush_clear", 32'(clear_instr_valid_o), 32'd1);
      chk("flush_ready", 32'(id_ready_o), 32'd0);
      tick(1'b0);
      flush_i          = 1'b0;
      instr_valid_id_i = 1'b0;
      mc_cycles_i      = '0;
      #1;
      chk("flush_run", 32'(id_ready_o), 32'd1);
      chk("flush_cnt", 32'(instr_cnt_o), 32'(exp_cnt));

      // 5. Halt while a valid instruction is stalled on ex_ready_i.
      instr_valid_id_i = 1'b1;
      pc_id_i          = 32'h200;
      ex_ready_i       = 1'b0;
      #1;
      chk("stall_ready", 32'(id_ready_o), 32'd0);
      tick(1'b0);
      halt_req_i = 1'b1;
      #1;
      chk("halt_req_if", 32'(halt_if_o), 32'd1);
      chk("halt_req_valid", 32'(id_valid_o), 32'd0);
      tick(1'b0);
      ex_ready_i = 1'b1;
      #1;
      chk("halt_valid", 32'(id_valid_o), 32'd0);
      chk("halt_ready", 32'(id_ready_o), 32'd0);
      chk("halt_if", 32'(halt_if_o), 32'd1);
      tick(1'b0);
      halt_req_i = 1'b0;
      #1;
      chk("halt_rel_if", 32'(halt_if_o), 32'd1);
      chk("halt_rel_valid", 32'(id_valid_o), 32'd0);
      tick(1'b0);
      chk("reissue_valid", 32'(id_valid_o), 32'd1);
      chk("reissue_pc", dec_pc_o, 32'h200);
      chk("reissue_if", 32'(halt_if_o), 32'd0);
      tick(1'b1);

      // 6. Ten more issues take the 4-bit counter from 7 past 15 to 1.
      for (int i = 0; i < 10; i++) begin
         pc_id_i = 32'h300 + 32'(4 * i);
         #1;
         chk("wrap_valid", 32'(id_valid_o), 32'd1);
         tick(1'b1);
      end
      instr_valid_id_i = 1'b0;
      #1;
      chk("wrap_cnt", 32'(instr_cnt_o), 32'd1);
      chk("wrap_model", 32'(instr_cnt_o), 32'(exp_cnt));

      // Fetch failure reported only in RUN with empty IF/ID and no flush.
      is_fetch_failed_i = 1'b1;
      #1;
      chk("ferr_on", 32'(fetch_err_o), 32'd1);
      chk("ferr_valid", 32'(id_valid_o), 32'd0);
      flush_i = 1'b1;
      #1;
      chk("ferr_flush", 32'(fetch_err_o), 32'd0);
      tick(1'b0);
      flush_i           = 1'b0;
      is_fetch_failed_i = 1'b0;

      // Illegal compressed instruction issues normally with the flag raised.
      instr_valid_id_i    = 1'b1;
      illegal_c_insn_id_i = 1'b1;
      #1;
      chk("illegal_flag", 32'(dec_illegal_o), 32'd1);
      chk("illegal_issue", 32'(id_valid_o), 32'd1);
      tick(1'b1);
      instr_valid_id_i = 1'b0;
      #1;
      chk("illegal_gated", 32'(dec_illegal_o), 32'd0);
      illegal_c_insn_id_i = 1'b0;
      chk("illegal_cnt", 32'(instr_cnt_o), 32'd2);

      // Asynchronous reset while in MULTI.
      instr_valid_id_i = 1'b1;
      mc_cycles_i      = 4'd2;
      tick(1'b0);
      instr_valid_id_i = 1'b0;
      #1;
      chk("pre_rst_multi", 32'(id_ready_o), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("arst_run", 32'(id_ready_o), 32'd1);
      chk("arst_cnt", 32'(instr_cnt_o), 32'd0);
      chk("arst_valid", 32'(id_valid_o), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
